// File: rtl/scan_mux_if.sv
// Bundle of scan_mux control inputs and display-path outputs.
// Latency: none (wires only).
// Backpressure: none; outputs are refreshed every clock.
interface scan_mux_if #(
  parameter int NUM_CH = 6,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3
);
  logic                     auto_en;
  logic [SEL_W-1:0]         man_sel;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [DATA_W-1:0]        data_out;
  logic [NUM_CH-1:0]        ch_onehot;
  logic [SEL_W-1:0]         cur_sel;
  logic                     tick_out;

  // Controller side: drives mode, select, enables and channel values.
  modport master (
    output auto_en, man_sel, ch_en, data_in,
    input  data_out, ch_onehot, cur_sel, tick_out
  );

  // Multiplexer side.
  modport slave (
    input  auto_en, man_sel, ch_en, data_in,
    output data_out, ch_onehot, cur_sel, tick_out
  );
endinterface

// File: rtl/scan_mux.sv
// Registered N:1 channel mux with prescaled auto-scan over enabled channels or manual select.
// Latency: 1 clock from any input change to data_out/ch_onehot/cur_sel; tick_out decodes the prescaler register.
// Backpressure: none; a new selection is registered every clock.
module scan_mux #(
  parameter int NUM_CH = 6,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3,
  parameter int DIV    = 50000
) (
  input logic       clk,
  input logic       rst,
  scan_mux_if.slave bus
);
  // Channel slots are padded out to the full select range, so an index past
  // NUM_CH reads a zero enable and naturally falls into the blank case.
  localparam int NSLOT = 2 ** SEL_W;
  localparam int PW    = $clog2(DIV);

  if (NSLOT < NUM_CH) begin : g_bad_sel_w
    $error("scan_mux: SEL_W too narrow for NUM_CH");
  end

  logic [PW-1:0]     presc;
  logic              tick;
  logic [NSLOT-1:0]  en_ext;
  logic [DATA_W-1:0] ch_val [NSLOT];
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  scan_nxt;
  logic [SEL_W-1:0]  nsel;
  logic              blank;
  logic [NSLOT-1:0]  oh_ext;
  logic [SEL_W-1:0]  cur_sel_q;
  logic [DATA_W-1:0] dout_q;
  logic [NUM_CH-1:0] oh_q;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_CH) begin : g_real
      assign en_ext[g] = bus.ch_en[g];
      assign ch_val[g] = bus.data_in[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign en_ext[g] = 1'b0;
      assign ch_val[g] = '0;
    end
  end

  assign tick = (presc == PW'(DIV - 1));

  // Free-running scan prescaler; independent of mode, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Ring search for the next enabled channel after cur_sel; walking from the
  // farthest candidate down lets the nearest one win, and cur_sel itself is
  // the last resort. Nothing enabled leaves the default (hold).
  always_comb begin
    scan_nxt = cur_sel_q;
    cand     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = SEL_W'((int'(cur_sel_q) + k) % NUM_CH);
      if (en_ext[cand]) begin
        scan_nxt = cand;
      end
    end
  end

  // Select the channel for this edge and decide whether it is blanked.
  always_comb begin
    if (!bus.auto_en) begin
      nsel = bus.man_sel;
    end else if (tick) begin
      nsel = scan_nxt;
    end else begin
      nsel = cur_sel_q;
    end
    blank  = !en_ext[nsel];
    oh_ext = {{(NSLOT-1){1'b0}}, 1'b1} << nsel;
  end

  // Output registers: selected index, value and strobe, zeroed when blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel_q <= '0;
      dout_q    <= '0;
      oh_q      <= '0;
    end else begin
      cur_sel_q <= nsel;
      if (blank) begin
        dout_q <= '0;
        oh_q   <= '0;
      end else begin
        dout_q <= ch_val[nsel];
        oh_q   <= oh_ext[NUM_CH-1:0];
      end
    end
  end

  assign bus.cur_sel   = cur_sel_q;
  assign bus.data_out  = dout_q;
  assign bus.ch_onehot = oh_q;
  assign bus.tick_out  = tick;
endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed vectors with literal expectations plus a
// cycle-by-cycle reference model compared on every falling edge.
// Runs with NUM_CH=6, DATA_W=4, SEL_W=3, DIV=4; channel i holds i+1.
module tb_scan_mux;
  localparam int NUM_CH = 6;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;
  localparam int DIV    = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  scan_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  scan_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: cycle counter for the prescaler, integer channel index,
  // and a forward search over enables on each scan tick.
  int   m_presc, m_sel, m_dout, m_oh, nxt;
  bit   m_valid = 1'b0;
  bit   tk, found;
  logic [NUM_CH*DATA_W-1:0] shifted;

  function automatic bit en_of(input int ch);
    return ((int'(bus.ch_en) >> ch) & 1) == 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_presc = 0; m_sel = 0; m_dout = 0; m_oh = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      tk  = (m_presc == DIV - 1);
      nxt = m_sel;
      if (!bus.auto_en) begin
        nxt = int'(bus.man_sel);
      end else if (tk) begin
        found = 1'b0;
        for (int s = 1; s <= NUM_CH; s++) begin
          if (!found && en_of((m_sel + s) % NUM_CH)) begin
            found = 1'b1;
            nxt   = (m_sel + s) % NUM_CH;
          end
        end
      end
      m_presc = (m_presc + 1) % DIV;
      m_sel   = nxt;
      if (nxt < NUM_CH && en_of(nxt)) begin
        shifted = bus.data_in >> (nxt * DATA_W);
        m_dout  = int'(shifted[DATA_W-1:0]);
        m_oh    = 1 << nxt;
      end else begin
        m_dout = 0;
        m_oh   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_cur_sel",   32'(bus.cur_sel),   32'(m_sel));
      chk("model_data_out",  32'(bus.data_out),  32'(m_dout));
      chk("model_ch_onehot", 32'(bus.ch_onehot), 32'(m_oh));
      chk("model_tick_out",  32'(bus.tick_out),  32'(m_presc == DIV - 1));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string tag, input int sel, input int d, input int oh, input int t);
    chk({tag, "_cur_sel"},   32'(bus.cur_sel),   32'(sel));
    chk({tag, "_data_out"},  32'(bus.data_out),  32'(d));
    chk({tag, "_ch_onehot"}, 32'(bus.ch_onehot), 32'(oh));
    chk({tag, "_tick_out"},  32'(bus.tick_out),  32'(t));
  endtask

  initial begin
    rst         = 1'b1;
    bus.auto_en = 1'b0;
    bus.man_sel = '0;
    bus.ch_en   = '0;
    bus.data_in = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    step(2);
    pin("reset", 0, 0, 0, 0);

    // Full auto scan over all six channels.
    rst = 1'b0; bus.auto_en = 1'b1; bus.ch_en = 6'b111111;
    step(1); pin("t1_first", 0, 1, 1, 0);
    step(2); pin("t1_tick", 0, 1, 1, 1);
    step(1); pin("t1_adv1", 1, 2, 2, 0);
    for (int k = 2; k <= 6; k++) begin
      step(4); pin($sformatf("t1_adv%0d", k), k % 6, (k % 6) + 1, 1 << (k % 6), 0);
    end

    // Sparse enable mask skips disabled channels.
    bus.ch_en = 6'b010101;
    step(4); pin("t2_c2", 2, 3, 4, 0);
    step(4); pin("t2_c4", 4, 5, 16, 0);
    step(4); pin("t2_c0", 0, 1, 1, 0);
    step(4); pin("t2_c2b", 2, 3, 4, 0);

    // Value change on the resting channel shows one clock later.
    bus.data_in[2*DATA_W +: DATA_W] = 4'd9;
    step(1); pin("t5_val9", 2, 9, 4, 0);
    bus.data_in[2*DATA_W +: DATA_W] = 4'd3;
    step(1); pin("t5_val3", 2, 3, 4, 0);

    // No channels enabled: blank and hold, then a lone channel is found.
    bus.ch_en = 6'b000000;
    step(1); pin("t3_blank", 2, 0, 0, 1);
    step(1); pin("t3_hold", 2, 0, 0, 0);
    bus.ch_en = 6'b001000;
    step(3); pin("t3_wait", 2, 0, 0, 1);
    step(1); pin("t3_c3", 3, 4, 8, 0);

    // Manual mode takes man_sel on the next edge; out-of-range blanks.
    bus.auto_en = 1'b0; bus.man_sel = 3'd4; bus.ch_en = 6'b111111;
    step(1); pin("t4_m4", 4, 5, 16, 0);
    bus.man_sel = 3'd7;
    step(1); pin("t4_m7", 7, 0, 0, 0);
    bus.man_sel = 3'd1;
    step(1); pin("t4_m1", 1, 2, 2, 1);
    bus.auto_en = 1'b1;
    step(1); pin("t4_resume", 2, 3, 4, 0);

    // Mid-scan reset with cur_sel=3, presc=2.
    step(4); pin("t6_c3", 3, 4, 8, 0);
    step(2); pin("t6_pre", 3, 4, 8, 0);
    rst = 1'b1;
    step(1); pin("t6_rst", 0, 0, 0, 0);
    rst = 1'b0;
    step(1); pin("t6_rel1", 0, 1, 1, 0);
    step(2); pin("t6_rel3", 0, 1, 1, 1);
    step(1); pin("t6_adv", 1, 2, 2, 0);

    // Single enabled channel: auto scan stays on it across ticks.
    bus.ch_en = 6'b000010;
    step(8); pin("single_a", 1, 2, 2, 0);
    step(3); pin("single_b", 1, 2, 2, 1);

    step(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
